// File: rtl/sdsp_syn_update_pkg.sv
// Shared definitions for the SDSP synapse update block: FSM states and synapse word layout.
package sdsp_syn_update_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MOD  = 3'd2,
        WR   = 3'd3,
        ACK  = 3'd4,
        REL  = 3'd5
    } state_t;

    localparam int unsigned SYN_BITS     = 4;
    localparam int unsigned SYN_PER_WORD = 8;
    localparam logic [2:0]  WMAX         = 3'd7;

endpackage

// File: rtl/sdsp_word_update.sv
// Combinational SDSP update of one 32-bit synapse word (8 synapses x {map bit, 3-bit weight}).
module sdsp_word_update
    import sdsp_syn_update_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [7:0]  up,
    input  logic [7:0]  down,
    output logic [31:0] wdata
);

    logic [2:0] w;

    always_comb begin
        wdata = rdata;
        w     = '0;
        for (int unsigned j = 0; j < SYN_PER_WORD; j++) begin
            w = rdata[j*SYN_BITS +: 3];
            // Only mapped synapses learn; saturated or conflicting conditions hold the weight.
            if (rdata[j*SYN_BITS + 3]) begin
                if (up[j] && !down[j] && (w != WMAX))
                    w = w + 3'd1;
                else if (down[j] && !up[j] && (w != 3'd0))
                    w = w - 3'd1;
            end
            wdata[j*SYN_BITS +: 3] = w;
        end
    end

endmodule

// File: rtl/sdsp_syn_update.sv
// SDSP synapse row walker: holds the up/down condition table and read-modify-writes one
// pre-synaptic neuron's synapse row in SRAM per spike request.
module sdsp_syn_update #(
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int SYN_AW = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LEARN_EN,
    input  logic              PRE_REQ,
    input  logic [ADDR_W-1:0] PRE_ADDR,
    output logic              PRE_ACK,
    output logic              BUSY,
    input  logic              VUD_WE,
    input  logic [ADDR_W-1:0] VUD_ADDR,
    input  logic              V_UP,
    input  logic              V_DOWN,
    output logic              SYN_CS,
    output logic              SYN_WE,
    output logic [SYN_AW-1:0] SYN_ADDR,
    output logic [31:0]       SYN_WDATA,
    input  logic [31:0]       SYN_RDATA
);

    import sdsp_syn_update_pkg::*;

    localparam int WORD_W = SYN_AW - ADDR_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N/8 - 1);

    state_t            state;
    logic [ADDR_W-1:0] pre;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] next_word;
    logic [N-1:0]      up_tbl;
    logic [N-1:0]      dn_tbl;
    logic [7:0]        word_up;
    logic [7:0]        word_dn;
    logic [31:0]       new_word;

    assign next_word = word + WORD_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            up_tbl <= '0;
            dn_tbl <= '0;
        end else if (VUD_WE) begin
            up_tbl[VUD_ADDR] <= V_UP;
            dn_tbl[VUD_ADDR] <= V_DOWN;
        end
    end

    // Table read is taken before any same-cycle write lands, so the old pair is used.
    assign word_up = up_tbl[{word, 3'b000} +: SYN_PER_WORD];
    assign word_dn = dn_tbl[{word, 3'b000} +: SYN_PER_WORD];

    sdsp_word_update u_word_update (
        .rdata (SYN_RDATA),
        .up    (word_up),
        .down  (word_dn),
        .wdata (new_word)
    );

    // Outputs are registered from the next state, so each drives during its own state's cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            pre       <= '0;
            word      <= '0;
            PRE_ACK   <= 1'b0;
            BUSY      <= 1'b0;
            SYN_CS    <= 1'b0;
            SYN_WE    <= 1'b0;
            SYN_ADDR  <= '0;
            SYN_WDATA <= '0;
        end else begin
            PRE_ACK   <= 1'b0;
            SYN_CS    <= 1'b0;
            SYN_WE    <= 1'b0;
            SYN_ADDR  <= '0;
            SYN_WDATA <= '0;
            case (state)
                IDLE: begin
                    if (PRE_REQ) begin
                        pre  <= PRE_ADDR;
                        word <= '0;
                        BUSY <= 1'b1;
                        if (LEARN_EN) begin
                            state    <= RD;
                            SYN_CS   <= 1'b1;
                            SYN_ADDR <= {PRE_ADDR, {WORD_W{1'b0}}};
                        end else begin
                            state   <= ACK;
                            PRE_ACK <= 1'b1;
                        end
                    end
                end
                RD: state <= MOD;
                MOD: begin
                    state     <= WR;
                    SYN_CS    <= 1'b1;
                    SYN_WE    <= 1'b1;
                    SYN_ADDR  <= {pre, word};
                    SYN_WDATA <= new_word;
                end
                WR: begin
                    if (word == LAST_WORD) begin
                        state   <= ACK;
                        PRE_ACK <= 1'b1;
                    end else begin
                        state    <= RD;
                        word     <= next_word;
                        SYN_CS   <= 1'b1;
                        SYN_ADDR <= {pre, next_word};
                    end
                end
                ACK: state <= REL;
                REL: begin
                    if (!PRE_REQ) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdsp_syn_update.sv
// Scoreboard bench for sdsp_syn_update: SRAM and condition-table models predict every write.
module tb_sdsp_syn_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        learn_en;
    logic        pre_req;
    logic [7:0]  pre_addr;
    logic        pre_ack;
    logic        busy;
    logic        vud_we;
    logic [7:0]  vud_addr;
    logic        v_up;
    logic        v_down;
    logic        syn_cs;
    logic        syn_we;
    logic [12:0] syn_addr;
    logic [31:0] syn_wdata;
    logic [31:0] syn_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem [0:8191];
    logic [255:0] t_up;
    logic [255:0] t_dn;
    logic         ld_en;
    logic [12:0]  ld_addr;
    logic [31:0]  ld_data;

    logic [7:0]   exp_pre;
    logic [4:0]   rd_idx;
    int           rd_cnt;
    int           wr_cnt;
    logic [44:0]  sbq [$];

    always #5 clk = ~clk;

    sdsp_syn_update #(.N(256), .ADDR_W(8), .SYN_AW(13)) dut (
        .CLK       (clk),
        .RST       (rst),
        .LEARN_EN  (learn_en),
        .PRE_REQ   (pre_req),
        .PRE_ADDR  (pre_addr),
        .PRE_ACK   (pre_ack),
        .BUSY      (busy),
        .VUD_WE    (vud_we),
        .VUD_ADDR  (vud_addr),
        .V_UP      (v_up),
        .V_DOWN    (v_down),
        .SYN_CS    (syn_cs),
        .SYN_WE    (syn_we),
        .SYN_ADDR  (syn_addr),
        .SYN_WDATA (syn_wdata),
        .SYN_RDATA (syn_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] r, input logic [4:0] wi);
        logic [31:0] o;
        logic [3:0]  nib;
        int          p;
        o = r;
        for (int j = 0; j < 8; j++) begin
            nib = r[4*j +: 4];
            p   = int'(wi) * 8 + j;
            if (nib[3] && t_up[p] && !t_dn[p] && nib[2:0] != 3'd7) nib = nib + 4'd1;
            else if (nib[3] && t_dn[p] && !t_up[p] && nib[2:0] != 3'd0) nib = nib - 4'd1;
            o[4*j +: 4] = nib;
        end
        return o;
    endfunction

    // Synchronous SRAM model, also accepting bench preloads.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (syn_cs && !syn_we) syn_rdata <= mem[syn_addr];
        if (syn_cs && syn_we) mem[syn_addr] <= syn_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_up <= '0;
            t_dn <= '0;
        end else if (vud_we) begin
            t_up[vud_addr] <= v_up;
            t_dn[vud_addr] <= v_down;
        end
    end

    always @(negedge clk) begin
        logic [44:0] e;
        if (!rst) begin
            if (syn_cs && !syn_we) begin
                check("rd_addr", 64'(syn_addr), 64'({exp_pre, rd_idx}));
                check("rd_wdata_zero", 64'(syn_wdata), 64'd0);
                sbq.push_back({syn_addr, model_word(mem[syn_addr], syn_addr[4:0])});
                rd_idx = rd_idx + 5'd1;
                rd_cnt++;
            end else if (syn_cs && syn_we) begin
                wr_cnt++;
                if (sbq.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("wr_addr", 64'(syn_addr), 64'(e[44:32]));
                    check("wr_data", 64'(syn_wdata), 64'(e[31:0]));
                end
            end else begin
                check("idle_sram_outs", 64'({syn_we, syn_addr, syn_wdata}), 64'd0);
            end
        end
    end

    task automatic load(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic vud(input logic [7:0] a, input logic u, input logic d);
        @(negedge clk);
        vud_we = 1'b1; vud_addr = a; v_up = u; v_down = d;
        @(negedge clk);
        vud_we = 1'b0;
    endtask

    task automatic do_req(input logic [7:0] p, input logic le, input int hold,
                          input int inject_at, input int abort_at, input int exp_ack);
        int n;
        bit got;
        @(negedge clk);
        exp_pre = p; rd_idx = '0; rd_cnt = 0; wr_cnt = 0; sbq.delete();
        pre_req = 1'b1; pre_addr = p; learn_en = le;
        @(posedge clk);
        n = 1; got = 1'b0;
        @(negedge clk);
        pre_addr = ~p; learn_en = ~le;
        while (!got && n < 400) begin
            if (n == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("abort_outs", 64'({pre_ack, busy, syn_cs, syn_we, syn_addr, syn_wdata}), 64'd0);
                @(negedge clk);
                rst = 1'b0; pre_req = 1'b0; vud_we = 1'b0;
                sbq.delete();
                @(negedge clk);
                check("abort_idle", 64'(busy), 64'd0);
                return;
            end
            if (n == inject_at) begin
                vud_we = 1'b1; vud_addr = 8'd9; v_up = 1'b1; v_down = 1'b0;
            end else begin
                vud_we = 1'b0;
            end
            if (pre_ack) begin
                got = 1'b1;
                check("ack_cycle", 64'(n), 64'(exp_ack));
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) check("ack_timeout", 64'd0, 64'd1);
        vud_we = 1'b0;
        @(negedge clk);
        check("ack_pulse", 64'(pre_ack), 64'd0);
        for (int i = 0; i < hold; i++) begin
            check("busy_rel", 64'(busy), 64'd1);
            @(negedge clk);
        end
        pre_req = 1'b0;
        @(negedge clk);
        check("idle_after_rel", 64'(busy), 64'd0);
        if (le) begin
            check("wr_count", 64'(wr_cnt), 64'd32);
            check("sb_empty", 64'(sbq.size()), 64'd0);
        end else begin
            check("no_sram_access", 64'(rd_cnt + wr_cnt), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; learn_en = 1'b0; pre_req = 1'b0; pre_addr = '0;
        vud_we = 1'b0; vud_addr = '0; v_up = 1'b0; v_down = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        exp_pre = '0; rd_idx = '0; rd_cnt = 0; wr_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({pre_ack, busy, syn_cs, syn_we, syn_addr, syn_wdata}), 64'd0);
        rst = 1'b0;

        for (int w = 0; w < 32; w++) begin
            load({8'd5, 5'(w)}, $urandom);
            load({8'd7, 5'(w)}, $urandom);
            load({8'd9, 5'(w)}, $urandom);
        end
        @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);

        // All conditions clear: every word written back unchanged.
        do_req(8'd5, 1'b1, 0, 0, 0, 97);

        load({8'd5, 5'd0}, 32'h0000_0F8B);
        vud(8'd0, 1'b1, 1'b0);
        vud(8'd1, 1'b0, 1'b1);
        do_req(8'd5, 1'b1, 0, 0, 0, 97);
        check("t2_word", 64'(mem[{8'd5, 5'd0}]), 64'h0000_0F8C);

        // Saturated up, saturated down, unmapped with up, and conflicting up+down.
        load({8'd7, 5'd0}, 32'h0000_C28F);
        vud(8'd2, 1'b1, 1'b0);
        vud(8'd3, 1'b1, 1'b1);
        do_req(8'd7, 1'b1, 0, 0, 0, 97);
        check("t3_word", 64'(mem[{8'd7, 5'd0}]), 64'h0000_C28F);

        do_req(8'd3, 1'b0, 10, 0, 0, 1);

        // Table write during MOD of word 1 must not affect that word.
        load({8'd9, 5'd1}, 32'h0000_0090);
        do_req(8'd9, 1'b1, 0, 5, 0, 97);
        check("t5_old_value", 64'(mem[{8'd9, 5'd1}]), 64'h0000_0090);
        do_req(8'd9, 1'b1, 0, 0, 0, 97);
        check("t5_new_value", 64'(mem[{8'd9, 5'd1}]), 64'h0000_00A0);

        // Reset during WR of word 10 (cycle 33); table cleared, walk restarts at word 0.
        do_req(8'd5, 1'b1, 0, 0, 33, 97);
        check("t6_word0_before", 64'(mem[{8'd5, 5'd0}]), 64'h0000_0F8D);
        do_req(8'd5, 1'b1, 0, 0, 0, 97);
        check("t6_word0_after", 64'(mem[{8'd5, 5'd0}]), 64'h0000_0F8D);
        do_req(8'd9, 1'b1, 0, 0, 0, 97);
        check("t6_post9_cleared", 64'(mem[{8'd9, 5'd1}]), 64'h0000_00A0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdsp_syn_update.md
Name: sdsp_syn_update

Overview:
- Consumer end of the SDSP up/down condition interface.
- Neuron update logic writes one v_up/v_down pair per post-synaptic neuron into this block's condition table.
- On a pre-synaptic spike request, the block walks the pre-synaptic neuron's synapse row in synapse SRAM and applies the SDSP weight update with read-modify-write.
- It sits between the controller (spike requests) and the synapse SRAM port.

Parameters:
N, 256, number of post-synaptic neurons (power of 2, multiple of 8).
ADDR_W, 8, log2(N); width of neuron indices.
SYN_AW, 13, synapse SRAM address width = ADDR_W + log2(N/8).

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
LEARN_EN  in  1  global SDSP learning enable, sampled at request accept
PRE_REQ  in  1  pre-synaptic spike update request (4-phase level)
PRE_ADDR  in  ADDR_W  pre-synaptic neuron index, valid while PRE_REQ high
PRE_ACK  out  1  one-cycle completion pulse
BUSY  out  1  high in every state except IDLE
VUD_WE  in  1  condition table write strobe from neuron update logic
VUD_ADDR  in  ADDR_W  post-synaptic neuron index for table write
V_UP  in  1  SDSP UP condition of neuron VUD_ADDR
V_DOWN  in  1  SDSP DOWN condition of neuron VUD_ADDR
SYN_CS  out  1  synapse SRAM chip select
SYN_WE  out  1  synapse SRAM write enable
SYN_ADDR  out  SYN_AW  {pre index, word index}
SYN_WDATA  out  32  write data: 8 synapses x 4 bits; synapse j in bits [4j+3:4j]
SYN_RDATA  in  32  read data, valid in the cycle after a read (synchronous SRAM)

Behaviour:
Reset:
- Table (N x {up,down}) cleared to 0.
- FSM goes to IDLE.
- PRE_ACK, BUSY, SYN_CS, SYN_WE = 0; SYN_ADDR and SYN_WDATA = 0.
- RST mid-walk aborts immediately; there is no SRAM write in the reset cycle.

Condition table:
- VUD_WE writes {V_UP, V_DOWN} at VUD_ADDR at the clock edge. This happens in any state.
- A compute in the same cycle as a write to the same entry uses the old value.

Synapse format:
- bit3 = learn-enable mapping bit; bits[2:0] = weight w.

FSM states: IDLE, RD, MOD, WR, ACK, REL.
- IDLE: on PRE_REQ=1, latch PRE_ADDR and LEARN_EN, set word index=0.
  - If LEARN_EN=1, go to RD.
  - If LEARN_EN=0, go to ACK (no SRAM access).
- RD: SYN_CS=1, SYN_WE=0, SYN_ADDR={pre,word}. Go to MOD.
- MOD: register the computed word for all 8 synapses j (post neuron = word*8+j):
  - If bit3=0, the synapse is unchanged.
  - If up=1, down=0 and w!=7, w+1.
  - If down=1, up=0 and w!=0, w-1.
  - Otherwise (saturated, or both bits set), w is held.
  - Bit3 is never modified.
  - Go to WR.
- WR: SYN_CS=1, SYN_WE=1, same address, SYN_WDATA=registered word.
  - If word = N/8-1, go to ACK; else increment word and go to RD.
  - The word index does not wrap.
- ACK: PRE_ACK=1 for exactly one cycle. Go to REL.
- REL: wait until PRE_REQ=0, then go to IDLE. A new request is accepted only in IDLE.

SRAM outputs are 0 outside RD/WR.

Latency, with the accept edge as cycle 0:
- Word k: RD at 1+3k, MOD at 2+3k, WR at 3+3k.
- PRE_ACK is high in cycle 3*(N/8)+1 (97 for N=256).
- With learning disabled, PRE_ACK is high in cycle 1.

Changes to PRE_ADDR or LEARN_EN after accept have no effect.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams).
  - SYN_BITS=4, SYN_PER_WORD=8, WMAX=3'd7.
- One natural sub-module: sdsp_word_update. It is combinational, maps 32-bit rdata plus 8 up/down pairs to 32-bit wdata, and is instantiated in the MOD stage.

Test Plan:
1. Reset, then pre=5 with LEARN_EN=1, all table entries 0. Expect 32 read/write pairs at addresses {5,0..31}; each wdata equals its rdata; PRE_ACK at cycle 97.
2. Table post 0 up=1, post 1 down=1. SRAM word {5,0} = 0x0000_0F8B (syn0=0xB: bit3=1, w=3; syn1=0x8: bit3=1, w=0; syn2=0xF). Expect wdata 0x0000_0F8C: syn0 w 3->4; syn1 at w=0 holds; syn2 post 2 up=down=0 holds.
3. Saturation: syn w=7 with up, syn w=0 with down, syn bit3=0 with up. Expect all three unchanged; a post with up=down=1 is unchanged.
4. LEARN_EN=0 at request. Expect no SYN_CS assertion; PRE_ACK in cycle 1. PRE_REQ held high for 10 more cycles: BUSY stays 1 in REL; IDLE is entered one cycle after PRE_REQ falls.
5. VUD_WE sets post 9 up=1 in the MOD cycle of word 1. Expect the old value used for that word. A second request sees the new value and increments post 9.
6. RST asserted during the WR of word 10. Expect outputs 0 asynchronously, table cleared; the next request starts at word 0.
